// File: rtl/lfsr_period_monitor.sv
// Period / lock-up / tail checker for a 4-bit LFSR state stream.
// Captures the first valid state as reference and counts samples until it recurs.
module lfsr_period_monitor #(
  parameter int MAX_LEN = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       valid,
  input  logic [3:0] data_in,
  output logic       busy,
  output logic       done,
  output logic [4:0] period,
  output logic       maximal,
  output logic       lockup,
  output logic       repeat_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t      state_r, state_s;
  logic [3:0]  ref_r, ref_s;
  logic [15:0] seen_r, seen_s;
  logic [4:0]  count_r, count_s;
  logic [4:0]  period_s;
  logic        maximal_s, lockup_s, repeat_err_s;
  logic        busy_s, done_s;

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_s      = state_r;
    ref_s        = ref_r;
    seen_s       = seen_r;
    count_s      = count_r;
    period_s     = period;
    maximal_s    = maximal;
    lockup_s     = lockup;
    repeat_err_s = repeat_err;

    if (start) begin
      // start wins over valid in every state; the sample is discarded
      state_s      = ARM;
      ref_s        = 4'd0;
      seen_s       = 16'd0;
      count_s      = 5'd0;
      period_s     = 5'd0;
      maximal_s    = 1'b0;
      lockup_s     = 1'b0;
      repeat_err_s = 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        ARM: begin
          if (valid) begin
            ref_s            = data_in;
            seen_s[data_in]  = 1'b1;
            count_s          = 5'd1;
            if (data_in == 4'd0) begin
              // all-zero is a fixed point of the LFSR
              state_s   = DONE;
              lockup_s  = 1'b1;
              period_s  = 5'd1;
              maximal_s = 1'b0;
            end else begin
              state_s = RUN;
            end
          end else begin
            state_s = ARM;
          end
        end
        RUN: begin
          if (valid) begin
            if (data_in == ref_r) begin
              state_s   = DONE;
              period_s  = count_r;
              maximal_s = (count_r == 5'(MAX_LEN)) && !lockup;
            end else if (seen_r[data_in]) begin
              state_s      = DONE;
              repeat_err_s = 1'b1;
              period_s     = 5'd0;
              maximal_s    = 1'b0;
            end else begin
              seen_s[data_in] = 1'b1;
              count_s         = count_r + 5'd1;
              if (data_in == 4'd0) begin
                lockup_s = 1'b1;
              end else begin
                lockup_s = lockup;
              end
            end
          end else begin
            state_s = RUN;
          end
        end
        DONE: begin
          state_s = DONE;
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end

    busy_s = (state_s == ARM) || (state_s == RUN);
    done_s = (state_s == DONE);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r    <= IDLE;
      ref_r      <= 4'd0;
      seen_r     <= 16'd0;
      count_r    <= 5'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      period     <= 5'd0;
      maximal    <= 1'b0;
      lockup     <= 1'b0;
      repeat_err <= 1'b0;
    end else begin
      state_r    <= state_s;
      ref_r      <= ref_s;
      seen_r     <= seen_s;
      count_r    <= count_s;
      busy       <= busy_s;
      done       <= done_s;
      period     <= period_s;
      maximal    <= maximal_s;
      lockup     <= lockup_s;
      repeat_err <= repeat_err_s;
    end
  end

endmodule

// File: tb/tb_lfsr_period_monitor.sv
// Directed self-checking bench for lfsr_period_monitor.
// Inputs change on the falling edge; outputs are checked 1 time unit after the rising edge.
module tb_lfsr_period_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic       valid = 1'b0;
  logic [3:0] data_in = 4'd0;
  logic       busy, done, maximal, lockup, repeat_err;
  logic [4:0] period;

  int checks = 0;
  int errors = 0;

  logic [3:0] seq [16] = '{4'hF, 4'h7, 4'h3, 4'h1, 4'h8, 4'h4, 4'h2, 4'h9,
                           4'hC, 4'h6, 4'hB, 4'h5, 4'hA, 4'hD, 4'hE, 4'hF};

  lfsr_period_monitor #(.MAX_LEN(15)) dut (
    .clk(clk), .rst(rst), .start(start), .valid(valid), .data_in(data_in),
    .busy(busy), .done(done), .period(period), .maximal(maximal),
    .lockup(lockup), .repeat_err(repeat_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic step(input logic s, input logic v, input logic [3:0] d);
    @(negedge clk);
    start   = s;
    valid   = v;
    data_in = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    valid = 1'b0;
  endtask

  task automatic check_result(input string tag, input int dn, input int per,
                              input int mx, input int lk, input int re);
    check({tag, "_done"}, int'(done), dn);
    check({tag, "_period"}, int'(period), per);
    check({tag, "_maximal"}, int'(maximal), mx);
    check({tag, "_lockup"}, int'(lockup), lk);
    check({tag, "_repeat"}, int'(repeat_err), re);
  endtask

  initial begin
    // Reset state
    #12;
    check_result("reset", 0, 0, 0, 0, 0);
    check("reset_busy", int'(busy), 0);
    rst = 1'b1;
    step(1'b0, 1'b1, 4'h3);
    check("idle_valid_ignored_busy", int'(busy), 0);

    // Maximal sequence, valid continuous
    step(1'b1, 1'b0, 4'h0);
    check("max_busy", int'(busy), 1);
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, seq[i]);
    check("max_done_early", int'(done), 0);
    check("max_busy_run", int'(busy), 1);
    step(1'b0, 1'b1, seq[15]);
    check_result("max", 1, 15, 1, 0, 0);
    check("max_busy_done", int'(busy), 0);

    // Maximal sequence with valid low every other cycle
    step(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 15; i++) begin
      step(1'b0, 1'b1, seq[i]);
      step(1'b0, 1'b0, seq[15]);
    end
    check("gap_done_early", int'(done), 0);
    step(1'b0, 1'b1, seq[15]);
    check_result("gap", 1, 15, 1, 0, 0);

    // Zero seed
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h0);
    check_result("zero", 1, 1, 0, 1, 0);

    // Tail: 1,2,3,2
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h1);
    step(1'b0, 1'b1, 4'h2);
    step(1'b0, 1'b1, 4'h3);
    check("tail_done_early", int'(done), 0);
    step(1'b0, 1'b1, 4'h2);
    check_result("tail", 1, 0, 0, 0, 1);

    // Short cycle 5,A,5 then restart from DONE (valid alongside start is dropped)
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h5);
    step(1'b0, 1'b1, 4'hA);
    step(1'b0, 1'b1, 4'h5);
    check_result("short", 1, 2, 0, 0, 0);
    step(1'b1, 1'b1, 4'h0);
    check_result("restart", 0, 0, 0, 0, 0);
    check("restart_busy", int'(busy), 1);

    // Zero sampled inside a run sets lockup and blocks maximal: 3,0,3
    step(1'b0, 1'b1, 4'h3);
    step(1'b0, 1'b1, 4'h0);
    check("lock_mid_flag", int'(lockup), 1);
    step(1'b0, 1'b1, 4'h3);
    check_result("lock_mid", 1, 2, 0, 1, 0);

    // Start in RUN restarts and discards the concurrent sample
    step(1'b1, 1'b0, 4'h0);
    step(1'b0, 1'b1, 4'h6);
    step(1'b1, 1'b1, 4'h6);
    check("rerun_busy", int'(busy), 1);
    step(1'b0, 1'b1, 4'h9);
    step(1'b0, 1'b1, 4'h6);
    step(1'b0, 1'b1, 4'h9);
    check_result("rerun", 1, 2, 0, 0, 0);

    // Reset mid-run, asserted between edges
    step(1'b1, 1'b0, 4'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, seq[i]);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_result("midrst", 0, 0, 0, 0, 0);
    check("midrst_busy", int'(busy), 0);
    @(negedge clk);
    rst = 1'b1;
    step(1'b1, 1'b0, 4'h0);
    check("post_rst_busy", int'(busy), 1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, seq[i]);
    check_result("post_rst", 1, 15, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lfsr_period_monitor.md
# lfsr_period_monitor

Downstream checker for the 4-bit LFSR stage. It consumes the LFSR's parallel state output, one sample per valid cycle. It measures the cycle length of the sequence from the first captured state back to that state, and flags lock-up (all-zero state) and non-cyclic repeats. It reports whether the sequence is maximal length. It sits directly after the LFSR; `valid` is driven by the LFSR's run condition (seed-load select deasserted).

## Interface
- `MAX_LEN`, default 15: period that qualifies as maximal for a 4-bit LFSR.
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: asynchronous, active-low reset (0 = reset).
- `start` in 1: single-cycle pulse; begins or restarts a measurement.
- `valid` in 1: `data_in` holds a new LFSR state this cycle.
- `data_in` in 4: LFSR state (the LFSR's `dff_out`).
- `busy` out 1: high in ARM and RUN.
- `done` out 1: high in DONE; held until next `start` or reset.
- `period` out 5: measured period; 0 on repeat error.
- `maximal` out 1: `period == MAX_LEN` and no lockup and no repeat error.
- `lockup` out 1: state 0000 was sampled during the measurement.
- `repeat_err` out 1: a previously seen non-reference state recurred (sequence has a tail).

## Operation
- Internal registers:
  - `ref[3:0]`: reference state.
  - `seen[15:0]`: bitmap indexed by state.
  - `count[4:0]`: sample counter.
  - `state`: one of IDLE, ARM, RUN, DONE.
- All outputs are registered.
- `rst` low, at any time and including mid-run: state goes to IDLE; `ref`, `seen`, `count` and every output clear to 0. Inputs are ignored while `rst` is low.
- IDLE: `start`=1 → ARM; clears `seen`, `count`, `period` and all flags. `valid` is ignored.
- ARM: waits for `valid`. On `valid`:
  - `ref`←`data_in`, `seen[data_in]`←1, `count`←1.
  - If `data_in`==0: go to DONE with `lockup`=1, `period`=1, `maximal`=0 (zero state is a fixed point).
  - Otherwise: go to RUN.
- RUN, on `valid`, evaluated in this priority order:
  1. `data_in`==`ref` → DONE; `period`←`count`; `maximal`←(`count`==`MAX_LEN`)&&!`lockup`.
  2. `seen[data_in]`==1 → DONE; `repeat_err`←1; `period`←0; `maximal`←0.
  3. Otherwise: `seen[data_in]`←1; `count`←`count`+1; if `data_in`==0 then `lockup`←1.
- RUN without `valid`: hold all registers.
- DONE: outputs frozen. `start` → ARM, clearing everything as from IDLE.
- `start` in ARM or RUN: restart to ARM with a full clear. A `valid` in that same cycle is discarded.
- `start` and `valid` together in IDLE or DONE: `start` wins; the sample is discarded.
- `count` never exceeds 16: the bitmap forces termination within 16 valid samples after capture, so no wrap or saturation logic is needed.

## Timing
- `busy` rises the cycle after `start` is sampled.
- The reference is captured on the first `valid` edge in ARM.
- `done`, `period`, `maximal`, `lockup` and `repeat_err` are all valid in the same cycle. That cycle is the one after the terminating valid sample's clock edge.
- For a maximal LFSR with `valid` held high continuously:
  - the capture sample is sample 1;
  - samples 2–15 are new states;
  - sample 16 equals `ref`;
  - `done` rises 1 cycle after sample 16.
- Gaps in `valid` stretch latency cycle-for-cycle and do not change any result.
- Reset deassertion takes effect at the next rising edge; the first `start` is accepted on or after that edge.

## Test plan
- Maximal sequence: reset, `start`, then feed the x^4+x^3+1 sequence from 1111 (1111, 0111, 0011, 0001, 1000, 0100, 0010, 1001, 1100, 0110, 1011, 0101, 1010, 1101, 1110, 1111) with `valid` high → `done`=1, `period`=15, `maximal`=1, `lockup`=0, `repeat_err`=0.
- Same sequence with `valid` low every other cycle → identical outputs; `done` rises 1 cycle after the 16th valid sample.
- Zero seed: `start`, then `valid` with 0000 → next cycle `done`=1, `lockup`=1, `period`=1, `maximal`=0.
- Tail: samples 0001, 0010, 0011, 0010 → `done`=1, `repeat_err`=1, `period`=0, `maximal`=0.
- Short cycle: samples 0101, 1010, 0101 → `period`=2, `maximal`=0. Then `start` in DONE → outputs clear; `busy`=1 the next cycle.
- Reset mid-run: assert `rst`=0 after 5 valid samples, between clock edges → all outputs 0 immediately. After release, a new `start` and the maximal sequence → `period`=15.
